// File: rtl/rx_sym_sched.sv
// Receive-side OFDM symbol scheduler: times CP skip, FFT SOP and useful window per symbol.
// Optional feature: define RX_SCHED_RESYNC_EN to let a sync pulse restart a running frame.
module rx_sym_sched #(
  parameter int NFFT          = 1024,
  parameter int CP_LEN        = 256,
  parameter int SYM_PER_FRAME = 8,
  parameter int SYNC_OFFSET   = 0,
  localparam int SAMP_W = ((NFFT + CP_LEN) > 1) ? $clog2(NFFT + CP_LEN) : 1,
  localparam int SYM_W  = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             sync_pulse,
  output logic             fft_sop,
  output logic             fft_win,
  output logic [SYM_W-1:0] sym_idx,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             resync
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    WIN,
    GAP
  } state_e;

  if (SYNC_OFFSET < 0 || SYNC_OFFSET >= NFFT + CP_LEN) begin : g_bad_offset
    $error("rx_sym_sched: SYNC_OFFSET must lie in 0..NFFT+CP_LEN-1");
  end
  if (NFFT < 1 || CP_LEN < 0 || SYM_PER_FRAME < 1) begin : g_bad_geometry
    $error("rx_sym_sched: NFFT and SYM_PER_FRAME must be >= 1, CP_LEN >= 0");
  end

  localparam state_e START_STATE = (SYNC_OFFSET == 0) ? WIN : ALIGN;
  localparam logic   START_SOP   = (SYNC_OFFSET == 0);
  localparam logic   CP_NONE     = (CP_LEN == 0);

  state_e             state_q, state_d;
  logic [SAMP_W-1:0]  samp_q, samp_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               sop_q, sop_d;
  logic               win_q, win_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               resync_q, resync_d;

  logic accept;
  logic restart;
  logic start;

  assign accept = (state_q == IDLE) && sync_pulse && sample_en;

`ifdef RX_SCHED_RESYNC_EN
  assign restart = (state_q != IDLE) && sync_pulse && sample_en;
`else
  assign restart = 1'b0;
`endif

  assign start = accept || restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      sym_q    <= '0;
      sop_q    <= 1'b0;
      win_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      sym_q    <= sym_d;
      sop_q    <= sop_d;
      win_q    <= win_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resync_q <= resync_d;
    end
  end

  // Everything advances on qualified samples only; a start (sync) overrides the running count.
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    sym_d    = sym_q;
    sop_d    = sop_q;
    done_d   = 1'b0;
    resync_d = 1'b0;
    if (start) begin
      state_d  = START_STATE;
      samp_d   = '0;
      sym_d    = '0;
      sop_d    = START_SOP;
      resync_d = restart;
    end else if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ALIGN: begin
          if (samp_q == SAMP_W'(SYNC_OFFSET - 1)) begin
            state_d = WIN;
            samp_d  = '0;
            sop_d   = 1'b1;
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        WIN: begin
          sop_d = 1'b0;
          if (samp_q == SAMP_W'(NFFT - 1)) begin
            samp_d = '0;
            if (sym_q == SYM_W'(SYM_PER_FRAME - 1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (CP_NONE) begin
              state_d = WIN;
              sym_d   = sym_q + SYM_W'(1);
              sop_d   = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        GAP: begin
          if (samp_q == SAMP_W'(CP_LEN - 1)) begin
            state_d = WIN;
            samp_d  = '0;
            sym_d   = sym_q + SYM_W'(1);
            sop_d   = 1'b1;
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Level outputs are registered from the next state so they line up with it.
  always_comb begin
    win_d  = (state_d == WIN);
    busy_d = (state_d != IDLE);
  end

  assign fft_sop    = sop_q;
  assign fft_win    = win_q;
  assign sym_idx    = sym_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign resync     = resync_q;

endmodule

// File: tb/tb_rx_sym_sched.sv
// Self-checking bench for rx_sym_sched; reference model tracks the qualified-sample index
// within the frame and derives every output from the symbol geometry.
module tb_rx_sym_sched;

  localparam int NFFT   = 16;
  localparam int CP     = 4;
  localparam int SPF    = 3;
  localparam int OFF    = 2;
  localparam int PERIOD = NFFT + CP;
  localparam int TOTAL  = OFF + SPF * PERIOD - CP;
`ifdef RX_SCHED_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic       sync_pulse;
  logic       fft_sop;
  logic       fft_win;
  logic [1:0] sym_idx;
  logic       frame_busy;
  logic       frame_done;
  logic       resync;

  int errors;
  int checks;

  int mActive;
  int mQ;
  int mSym;
  bit mDone;
  bit mResync;

  rx_sym_sched #(
    .NFFT          (NFFT),
    .CP_LEN        (CP),
    .SYM_PER_FRAME (SPF),
    .SYNC_OFFSET   (OFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .sync_pulse (sync_pulse),
    .fft_sop    (fft_sop),
    .fft_win    (fft_win),
    .sym_idx    (sym_idx),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .resync     (resync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit inWin(input int pos);
    return (pos >= OFF) && (((pos - OFF) % PERIOD) < NFFT);
  endfunction

  function automatic bit isStart(input int pos);
    return (pos >= OFF) && (((pos - OFF) % PERIOD) == 0);
  endfunction

  function automatic int symOf(input int pos);
    return (pos < OFF) ? 0 : (pos - OFF) / PERIOD;
  endfunction

  // Output packing: {sop, win, busy, done, resync, sym[1:0]}
  function automatic logic [6:0] modelExpect();
    logic [1:0] s;
    if (mActive != 0) begin
      s = 2'(symOf(mQ));
      return {isStart(mQ), inWin(mQ), 1'b1, mDone, mResync, s};
    end
    s = 2'(mSym);
    return {1'b0, 1'b0, 1'b0, mDone, mResync, s};
  endfunction

  task automatic modelAdvance(input bit en, input bit sy, input bit r);
    mDone   = 1'b0;
    mResync = 1'b0;
    if (r) begin
      mActive = 0;
      mQ      = 0;
      mSym    = 0;
    end else if (sy && en && (mActive == 0 || RESYNC)) begin
      mResync = (mActive != 0);
      mActive = 1;
      mQ      = 0;
      mSym    = 0;
    end else if (en && mActive != 0) begin
      mQ = mQ + 1;
      if (mQ == TOTAL) begin
        mActive = 0;
        mDone   = 1'b1;
        mSym    = SPF - 1;
      end
    end
  endtask

  task automatic stepCycle(input bit en, input bit sy, input bit r,
                           output logic [6:0] act, output logic [6:0] exp);
    sample_en  = en;
    sync_pulse = sy;
    rst        = r;
    exp = modelExpect();
    @(negedge clk);
    act = {fft_sop, fft_win, frame_busy, frame_done, resync, sym_idx};
    modelAdvance(en, sy, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] act, exp;
    stepCycle(1'b1, 1'b1, 1'b1, act, exp);
    checks++;
    if (act !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected %b", act, 7'd0);
    end
    for (int c = 0; c < 100; c++) begin
      stepCycle(1'b1, 1'b0, 1'b0, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL idle cycle %0d: got %b expected %b", c, act, exp);
      end
    end
  endtask

  task automatic test_frame();
    logic [6:0] act, exp;
    int sopAt[$];
    int doneAt[$];
    int busyFirst, busyLast;
    busyFirst = -1;
    busyLast  = -1;
    stepCycle(1'b1, 1'b0, 1'b1, act, exp);
    for (int c = 0; c < 70; c++) begin
      stepCycle(1'b1, c == 0, 1'b0, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL frame cycle %0d: got %b expected %b", c, act, exp);
      end
      if (act[6] === 1'b1) sopAt.push_back(c);
      if (act[3] === 1'b1) doneAt.push_back(c);
      if (act[4] === 1'b1) begin
        if (busyFirst < 0) busyFirst = c;
        busyLast = c;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sopAt.size() <= k || sopAt[k] != 3 + 20 * k) begin
        errors++;
        $display("[TB] FAIL frame_sop_time k=%0d: got %0d expected %0d", k,
                 (sopAt.size() > k) ? sopAt[k] : -1, 3 + 20 * k);
      end
    end
    checks++;
    if (doneAt.size() != 1 || doneAt[0] != 59) begin
      errors++;
      $display("[TB] FAIL frame_done_time: got count %0d first %0d expected one at 59",
               doneAt.size(), (doneAt.size() > 0) ? doneAt[0] : -1);
    end
    checks++;
    if (busyFirst != 1 || busyLast != 58) begin
      errors++;
      $display("[TB] FAIL frame_busy_span: got %0d..%0d expected 1..58", busyFirst, busyLast);
    end
  endtask

  task automatic test_sample_en_toggle();
    logic [6:0] act, exp;
    int winQ, sopQ, doneCnt;
    bit en;
    winQ = 0;
    sopQ = 0;
    doneCnt = 0;
    stepCycle(1'b1, 1'b0, 1'b1, act, exp);
    for (int c = 0; c < 140; c++) begin
      en = (c % 2 == 0);
      stepCycle(en, c == 0, 1'b0, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL toggle cycle %0d: got %b expected %b", c, act, exp);
      end
      if (act[5] === 1'b1 && en) winQ++;
      if (act[6] === 1'b1 && en) sopQ++;
      if (act[3] === 1'b1) doneCnt++;
    end
    checks++;
    if (winQ != 48 || sopQ != 3 || doneCnt != 1) begin
      errors++;
      $display("[TB] FAIL toggle_counts: got win=%0d sop=%0d done=%0d expected 48/3/1",
               winQ, sopQ, doneCnt);
    end
  endtask

  task automatic test_second_sync();
    logic [6:0] act, exp;
    int sopAt[$];
    int resyncAt;
    bit done59;
    resyncAt = -1;
    done59   = 1'b0;
    stepCycle(1'b1, 1'b0, 1'b1, act, exp);
    for (int c = 0; c < 70; c++) begin
      stepCycle(1'b1, (c == 0) || (c == 30), 1'b0, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL second_sync cycle %0d: got %b expected %b", c, act, exp);
      end
      if (act[6] === 1'b1) sopAt.push_back(c);
      if (act[2] === 1'b1 && resyncAt < 0) resyncAt = c;
      if (act[3] === 1'b1 && c == 59) done59 = 1'b1;
    end
`ifdef RX_SCHED_RESYNC_EN
    checks++;
    if (resyncAt != 31 || sopAt.size() < 3 || sopAt[2] != 33 || done59) begin
      errors++;
      $display("[TB] FAIL resync_timing: got resync=%0d third_sop=%0d done59=%0d expected 31/33/0",
               resyncAt, (sopAt.size() > 2) ? sopAt[2] : -1, done59);
    end
`else
    checks++;
    if (resyncAt != -1 || sopAt.size() != 3 || sopAt[1] != 23 || sopAt[2] != 43 || !done59) begin
      errors++;
      $display("[TB] FAIL ignored_sync: got resync=%0d sops=%0d done59=%0d expected -1/3/1",
               resyncAt, sopAt.size(), done59);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [6:0] act, exp;
    int sopAfter;
    bit done59;
    sopAfter = -1;
    done59   = 1'b0;
    stepCycle(1'b1, 1'b0, 1'b1, act, exp);
    for (int c = 0; c < 90; c++) begin
      stepCycle(1'b1, (c == 0) || (c == 59), 1'b0, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", c, act, exp);
      end
      if (act[6] === 1'b1 && c > 59 && sopAfter < 0) sopAfter = c;
      if (act[3] === 1'b1 && c == 59) done59 = 1'b1;
    end
    checks++;
    if (sopAfter != 62 || !done59) begin
      errors++;
      $display("[TB] FAIL back_to_back_sop: got sop=%0d done59=%0d expected 62/1", sopAfter, done59);
    end
  endtask

  task automatic test_reset_midframe();
    logic [6:0] act, exp;
    logic [6:0] at26;
    int sopAfter, doneCnt;
    sopAfter = -1;
    doneCnt  = 0;
    at26     = 7'h7f;
    stepCycle(1'b1, 1'b0, 1'b1, act, exp);
    for (int c = 0; c < 60; c++) begin
      stepCycle(1'b1, (c == 0) || (c == 40), c == 25, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL reset_midframe cycle %0d: got %b expected %b", c, act, exp);
      end
      if (c == 26) at26 = act;
      if (act[3] === 1'b1) doneCnt++;
      if (act[6] === 1'b1 && c > 40 && sopAfter < 0) sopAfter = c;
    end
    checks++;
    if (at26 !== 7'd0 || doneCnt != 0 || sopAfter != 43) begin
      errors++;
      $display("[TB] FAIL reset_midframe_summary: got out26=%b done=%0d sop=%0d expected 0/0/43",
               at26, doneCnt, sopAfter);
    end
  endtask

  task automatic test_random();
    logic [6:0] act, exp;
    bit en, sy, r;
    for (int c = 0; c < 4000; c++) begin
      en = ($urandom_range(0, 3) != 0);
      sy = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 999) == 0);
      stepCycle(en, sy, r, act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", c, act, exp);
      end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    sample_en  = 1'b0;
    sync_pulse = 1'b0;
    @(posedge clk);
    #1;
    mActive = 0;
    mQ      = 0;
    mSym    = 0;
    mDone   = 1'b0;
    mResync = 1'b0;
    $display("[TB] starting rx_sym_sched bench, resync feature=%0d", RESYNC);
    test_reset();
    test_frame();
    test_sample_en_toggle();
    test_second_sync();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
